// File: rtl/z8086_bus_mem_if.sv
// z8086 simplified CPU bus: the CPU drives the request side, the responder returns din/ready.
interface z8086_bus_mem_if;
   logic [19:0] addr;
   logic [15:0] dout;
   logic [15:0] din;
   logic        rd;
   logic        wr;
   logic        io;
   logic        word;
   logic        ready;

   modport master (output addr, dout, rd, wr, io, word, input din, ready);
   modport slave  (input addr, dout, rd, wr, io, word, output din, ready);
endinterface

// File: rtl/z8086_bus_mem.sv
// Memory + I/O responder for the z8086 bus with configurable/jittered wait states,
// sticky pass and protocol-error flags, and a byte-wide backdoor port.
module z8086_bus_mem #(
   parameter int          MEM_AW     = 16,
   parameter int          RD_LAT     = 1,
   parameter int          WR_LAT     = 0,
   parameter int          WS_MODE    = 0,
   parameter int          IO_PORTS   = 4,
   parameter logic [15:0] IO_DEFAULT = 16'hFFFF,
   parameter int          PASS_PORT  = 0,
   parameter logic [15:0] PASS_VALUE = 16'h1234
) (
   input  logic              clk,
   input  logic              reset_n,
   z8086_bus_mem_if.slave    bus,
   input  logic              bd_we,
   input  logic [MEM_AW-1:0] bd_addr,
   input  logic [7:0]        bd_wdata,
   output logic [7:0]        bd_rdata,
   output logic              pass,
   output logic              proto_err
);
   localparam int         MEM_SIZE = 1 << MEM_AW;
   localparam logic [4:0] NPORTS   = 5'(IO_PORTS);
   localparam logic [3:0] PPORT    = 4'(PASS_PORT);
   localparam logic [4:0] RD_L     = 5'(RD_LAT);
   localparam logic [4:0] WR_L     = 5'(WR_LAT);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state_q, state_d;

   logic [7:0]        mem [MEM_SIZE];
   logic [15:0]       io_reg [16];
   logic [MEM_AW-1:0] a_q, a_q_p1, wa, wa_p1;
   logic [3:0]        port, port_q, lfsr_q;
   logic              io_q, wr_q;
   logic [4:0]        cnt_q, cnt_d, lat;
   logic              req, accept, port_mapped, mem_we, io_we;
   logic              ready_d;
   logic [15:0]       din_d, mem_rdata, io_rdata;
   logic              unused_addr;

   assign req         = bus.rd | bus.wr;
   assign accept      = req && (state_q != WAIT);
   assign wa          = bus.addr[MEM_AW-1:0];
   assign wa_p1       = wa + MEM_AW'(1);
   assign a_q_p1      = a_q + MEM_AW'(1);
   assign port        = bus.addr[3:0];
   assign port_mapped = {1'b0, port} < NPORTS;
   assign mem_we      = accept && bus.wr && !bus.io;
   assign io_we       = accept && bus.wr && bus.io && port_mapped;
   assign unused_addr = ^bus.addr;

   // A zero-latency write landing in RESP would collide with the pending strobe; give it one cycle.
   always_comb begin
      lat = (bus.wr ? WR_L : RD_L) + ((WS_MODE == 1) ? {3'b000, lfsr_q[1:0]} : 5'd0);
      if (state_q == RESP && lat == 5'd0) lat = 5'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, RESP: begin
            state_d = IDLE;
            if (accept) begin
               cnt_d = lat;
               if (lat == 5'd1)      state_d = RESP;
               else if (lat != 5'd0) state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 5'd1;
            if (cnt_d == 5'd1) state_d = RESP;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_rdata = {mem[a_q_p1], mem[a_q]};
   assign io_rdata  = ({1'b0, port_q} < NPORTS) ? io_reg[port_q] : IO_DEFAULT;

   always_comb begin
      ready_d = 1'b0;
      din_d   = 16'h0000;
      if (state_q == RESP) begin
         ready_d = 1'b1;
         if (!wr_q) din_d = io_q ? io_rdata : mem_rdata;
      end else if (accept && lat == 5'd0) begin
         ready_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bus.ready <= 1'b0;
         bus.din   <= 16'h0000;
         lfsr_q    <= 4'b1001;
         pass      <= 1'b0;
         proto_err <= 1'b0;
         a_q       <= '0;
         port_q    <= 4'd0;
         io_q      <= 1'b0;
         wr_q      <= 1'b0;
         for (int i = 0; i < 16; i++) io_reg[i] <= 16'h0000;
      end else begin
         bus.ready <= ready_d;
         bus.din   <= din_d;
         if (accept) begin
            a_q    <= wa;
            port_q <= port;
            io_q   <= bus.io;
            wr_q   <= bus.wr;
            lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
         end
         if (req && (state_q == WAIT || (bus.rd && bus.wr))) proto_err <= 1'b1;
         if (io_we) begin
            if (bus.word) io_reg[port]      <= bus.dout;
            else          io_reg[port][7:0] <= bus.dout[7:0];
         end
         if (accept && bus.wr && bus.io && bus.word && port == PPORT && bus.dout == PASS_VALUE)
            pass <= 1'b1;
      end
   end

   // Bus write is issued after the backdoor write so it wins on a shared byte.
   always_ff @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_wdata;
      if (mem_we && reset_n) begin
         mem[wa] <= bus.dout[7:0];
         if (bus.word) mem[wa_p1] <= bus.dout[15:8];
      end
   end

   assign bd_rdata = mem[bd_addr];
endmodule
